// File: rtl/fsm.sv
// Single-cycle 16-bit execute core: 16-entry register file, ALU and flag register.
// One instruction word is decoded, executed and written back on every non-reset edge.
module fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] FullOp,
  input  logic [15:0] imm,
  output logic [15:0] aluOutput,
  output logic [4:0]  Flags
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDU, OP_ADDC,
    OP_SUB, OP_SUBC, OP_CMP, OP_MOV, OP_LUI, OP_SHIFT
  } alu_op_t;

  state_t      state_reg, state_next;
  alu_op_t     alu_op;
  logic [15:0] rf_q [16];
  logic [15:0] alu_reg;
  logic [4:0]  flags_reg, flags_next;
  logic [3:0]  opcode, rdest, ext, rsrc;
  logic [15:0] op_a, op_b, result;
  logic [16:0] wide;
  logic [4:0]  shift_neg;
  logic        wr_en, alu_en;

  assign opcode = FullOp[15:12];
  assign rdest  = FullOp[11:8];
  assign ext    = FullOp[7:4];
  assign rsrc   = FullOp[3:0];

  // Both operands come from the pre-edge register file, so Rdest==Rsrc is safe.
  assign op_a = rf_q[rdest];
  assign op_b = (opcode == 4'h0 || (opcode == 4'h8 && ext == 4'h4)) ? rf_q[rsrc] : imm;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = EXEC;
      EXEC:    state_next = EXEC;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_op = OP_NOP;
    case (opcode)
      4'h0: begin
        case (ext)
          4'h1:    alu_op = OP_AND;
          4'h2:    alu_op = OP_OR;
          4'h3:    alu_op = OP_XOR;
          4'h5:    alu_op = OP_ADD;
          4'h6:    alu_op = OP_ADDU;
          4'h7:    alu_op = OP_ADDC;
          4'h9:    alu_op = OP_SUB;
          4'hA:    alu_op = OP_SUBC;
          4'hB:    alu_op = OP_CMP;
          4'hD:    alu_op = OP_MOV;
          default: alu_op = OP_NOP;
        endcase
      end
      4'h1:    alu_op = OP_AND;
      4'h2:    alu_op = OP_OR;
      4'h3:    alu_op = OP_XOR;
      4'h5:    alu_op = OP_ADD;
      4'h6:    alu_op = OP_ADDU;
      4'h9:    alu_op = OP_SUB;
      4'hB:    alu_op = OP_CMP;
      4'hD:    alu_op = OP_MOV;
      4'hF:    alu_op = OP_LUI;
      4'h8:    alu_op = (ext == 4'h4 || ext == 4'h0) ? OP_SHIFT : OP_NOP;
      default: alu_op = OP_NOP;
    endcase
  end

  always_comb begin
    result     = '0;
    wide       = '0;
    shift_neg  = 5'd0 - op_b[4:0];
    flags_next = flags_reg;
    case (alu_op)
      OP_AND: result = op_a & op_b;
      OP_OR:  result = op_a | op_b;
      OP_XOR: result = op_a ^ op_b;
      OP_MOV: result = op_b;
      OP_LUI: result = {op_b[7:0], 8'h00};
      OP_ADD, OP_ADDU, OP_ADDC: begin
        wide   = {1'b0, op_a} + {1'b0, op_b} + {16'b0, (alu_op == OP_ADDC) & flags_reg[4]};
        result = wide[15:0];
        flags_next[4] = wide[16];
        if (alu_op != OP_ADDU)
          flags_next[2] = (op_a[15] == op_b[15]) && (result[15] != op_a[15]);
      end
      OP_SUB, OP_SUBC, OP_CMP: begin
        // Bit 16 of the 17-bit difference is the unsigned borrow.
        wide   = {1'b0, op_a} - {1'b0, op_b} - {16'b0, (alu_op == OP_SUBC) & flags_reg[4]};
        result = wide[15:0];
        if (alu_op == OP_CMP) begin
          flags_next[3] = wide[16];
          flags_next[1] = (op_a == op_b);
          flags_next[0] = ($signed(op_a) < $signed(op_b));
        end else begin
          flags_next[4] = wide[16];
          flags_next[2] = (op_a[15] != op_b[15]) && (result[15] != op_a[15]);
        end
      end
      // Negative amounts shift right by their magnitude; -16 clears the word.
      OP_SHIFT: result = op_b[4] ? (op_a >> shift_neg) : (op_a << op_b[3:0]);
      default:  result = '0;
    endcase
  end

  assign alu_en = (alu_op != OP_NOP);
  assign wr_en  = (alu_op != OP_NOP) && (alu_op != OP_CMP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      alu_reg   <= '0;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      flags_reg <= flags_next;
      if (alu_en)
        alu_reg <= result;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rf
      logic [15:0] entry_reg;
      always_ff @(posedge clk) begin
        if (rst)
          entry_reg <= '0;
        else if (wr_en && rdest == 4'(gi))
          entry_reg <= result;
      end
      assign rf_q[gi] = entry_reg;
    end
  endgenerate

  assign aluOutput = alu_reg;
  assign Flags     = flags_reg;

endmodule

// File: tb/tb_fsm.sv
// Directed bench for the fsm execute core: an integer-arithmetic reference model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] FullOp;
  logic [15:0] imm;
  logic [15:0] aluOutput;
  logic [4:0]  Flags;

  int n_vec = 0;
  int n_bad = 0;

  fsm dut (
    .clk(clk), .rst(rst), .FullOp(FullOp), .imm(imm),
    .aluOutput(aluOutput), .Flags(Flags)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on a register array.
  int  m_r [16];
  int  m_alu;
  bit  m_c, m_l, m_f, m_z, m_n;
  bit  m_valid = 1'b0;

  function automatic int sx(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic bit ovf(input int s);
    return (s > 32767) || (s < -32768);
  endfunction

  task automatic model_exec(input logic [15:0] op_w, input logic [15:0] im);
    int op, rd, ex, rs, a, b, res, cin, amt;
    string kind;
    op = int'(op_w[15:12]); rd = int'(op_w[11:8]);
    ex = int'(op_w[7:4]);   rs = int'(op_w[3:0]);
    a = m_r[rd];
    b = int'(im);
    kind = "nop";
    if (op == 0) begin
      b = m_r[rs];
      case (ex)
        1: kind = "and";  2: kind = "or";   3: kind = "xor";
        5: kind = "add";  6: kind = "addu"; 7: kind = "addc";
        9: kind = "sub";  10: kind = "subc"; 11: kind = "cmp";
        13: kind = "mov";
        default: kind = "nop";
      endcase
    end else if (op == 8) begin
      if (ex == 4) begin kind = "shift"; b = m_r[rs]; end
      else if (ex == 0) kind = "shift";
    end else begin
      case (op)
        1: kind = "and";  2: kind = "or";  3: kind = "xor";
        5: kind = "add";  6: kind = "addu"; 9: kind = "sub";
        11: kind = "cmp"; 13: kind = "mov"; 15: kind = "lui";
        default: kind = "nop";
      endcase
    end
    cin = m_c ? 1 : 0;
    res = 0;
    case (kind)
      "and":  res = a & b;
      "or":   res = a | b;
      "xor":  res = a ^ b;
      "mov":  res = b;
      "lui":  res = (b % 256) * 256;
      "add":  begin res = a + b; m_c = res > 65535; m_f = ovf(sx(a) + sx(b)); end
      "addu": begin res = a + b; m_c = res > 65535; end
      "addc": begin res = a + b + cin; m_c = res > 65535; m_f = ovf(sx(a) + sx(b) + cin); end
      "sub":  begin res = a - b; m_c = a < b; m_f = ovf(sx(a) - sx(b)); end
      "subc": begin res = a - b - cin; m_c = a < b + cin; m_f = ovf(sx(a) - sx(b) - cin); end
      "cmp":  begin res = a - b; m_z = (a == b); m_l = (a < b); m_n = (sx(a) < sx(b)); end
      "shift": begin
        amt = b % 32;
        if (amt > 15) amt = amt - 32;
        res = (amt >= 0) ? (a << amt) : (a >> (-amt));
      end
      default: res = 0;
    endcase
    res = res & 32'hFFFF;
    if (kind != "nop") m_alu = res;
    if (kind != "nop" && kind != "cmp") m_r[rd] = res;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_r[i] = 0;
      m_alu = 0;
      {m_c, m_l, m_f, m_z, m_n} = 5'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      model_exec(FullOp, imm);
    end
  end

  // Single compare process: outputs are stable on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      n_vec++;
      if (aluOutput !== 16'(m_alu) || Flags !== {m_c, m_l, m_f, m_z, m_n}) begin
        n_bad++;
        $display("FAIL model t=%0t: aluOutput=%h Flags=%b, required %h %b",
                 $time, aluOutput, Flags, 16'(m_alu), {m_c, m_l, m_f, m_z, m_n});
      end
    end
  end

  task automatic step(input logic [15:0] op, input logic [15:0] im);
    @(negedge clk);
    rst = 1'b0; FullOp = op; imm = im;
    @(posedge clk); #1;
    $display("step op=%h imm=%h -> aluOutput=%h Flags=%b", op, im, aluOutput, Flags);
  endtask

  task automatic do_reset(input int edges);
    @(negedge clk);
    rst = 1'b1; FullOp = 16'h5100; imm = 16'd5;
    repeat (edges) @(posedge clk);
    #1;
    $display("reset %0d edges -> aluOutput=%h Flags=%b", edges, aluOutput, Flags);
  endtask

  task automatic chk_alu(input string name, input logic [15:0] exp);
    n_vec++;
    if (aluOutput !== exp) begin
      n_bad++;
      $display("FAIL %s: aluOutput=%h required %h", name, aluOutput, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic [4:0] mask, input logic [4:0] exp);
    n_vec++;
    if ((Flags & mask) !== exp) begin
      n_bad++;
      $display("FAIL %s: Flags=%b (mask %b) required %b", name, Flags, mask, exp);
    end
  endtask

  logic [15:0] fib_exp [8] = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd1, 16'd3, 16'd2, 16'd5};
  logic [15:0] fib_ops [8] = '{16'h5000, 16'h5100, 16'h0250, 16'h0251,
                               16'h0351, 16'h0352, 16'h0452, 16'h0453};
  logic [15:0] fib_imm [8] = '{16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; FullOp = 16'h5100; imm = 16'd5;
    do_reset(2);
    chk_alu("reset_alu", 16'h0000);
    chk_flags("reset_flags", 5'b11111, 5'b00000);
    step(16'h2100, 16'h0000);
    chk_alu("reset_r1", 16'h0000);

    for (int i = 0; i <= 10; i++) begin
      step(16'h5100, 16'(i));
      chk_alu("accumulate", 16'(i * (i + 1) / 2));
    end
    chk_alu("accumulate_final", 16'h0037);
    chk_flags("accumulate_cf", 5'b10100, 5'b00000);

    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      step(fib_ops[i], fib_imm[i]);
      chk_alu("fibonacci", fib_exp[i]);
    end

    step(16'hD500, 16'h7FFF);
    step(16'h5500, 16'h0001);
    chk_alu("ovf_add", 16'h8000);
    chk_flags("ovf_add_flags", 5'b10100, 5'b00100);
    step(16'h5500, 16'h8000);
    chk_alu("carry_add", 16'h0000);
    chk_flags("carry_add_flags", 5'b10100, 5'b10100);

    step(16'hD600, 16'd3);
    step(16'hD700, 16'd5);
    step(16'h06B7, 16'h0000);
    chk_alu("cmp_result", 16'hFFFE);
    chk_flags("cmp_flags", 5'b01011, 5'b01001);
    step(16'h2600, 16'h0000);
    chk_alu("cmp_no_write", 16'h0003);
    step(16'hB700, 16'd5);
    chk_alu("cmpi_result", 16'h0000);
    chk_flags("cmpi_z", 5'b11111, 5'b10110);

    step(16'h0000, 16'h1234);
    chk_alu("nop_alu_hold", 16'h0000);
    chk_flags("nop_flags_hold", 5'b11111, 5'b10110);
    step(16'hD100, 16'd1);
    step(16'h8100, 16'd3);
    chk_alu("lshi_left", 16'h0008);
    step(16'h8100, 16'h001F);
    chk_alu("lshi_right", 16'h0004);
    chk_flags("shift_flags_hold", 5'b11111, 5'b10110);

    step(16'hD200, 16'h0001);
    step(16'hD300, 16'h000F);
    step(16'h8243, 16'h0000);
    chk_alu("lsh_left15", 16'h8000);
    step(16'hD300, 16'h0010);
    step(16'h8243, 16'h0000);
    chk_alu("lsh_right16", 16'h0000);

    step(16'hD400, 16'h0000);
    step(16'hD800, 16'h0001);
    step(16'h0498, 16'h0000);
    chk_alu("sub_borrow", 16'hFFFF);
    chk_flags("sub_borrow_flags", 5'b10100, 5'b10000);
    step(16'h0478, 16'h0000);
    chk_alu("addc", 16'h0001);
    step(16'h04A8, 16'h0000);
    chk_alu("subc", 16'hFFFF);

    step(16'hD900, 16'hF0F0);
    step(16'h3900, 16'hFF00);
    chk_alu("xori", 16'h0FF0);
    step(16'h1900, 16'h00FF);
    step(16'h0928, 16'h0000);
    chk_alu("and_or", 16'h00F1);
    step(16'hFA00, 16'h12AB);
    chk_alu("lui", 16'hAB00);
    step(16'h0A6A, 16'h0000);
    chk_alu("addu_self", 16'h5600);
    step(16'h0A4A, 16'h0000);
    step(16'h4A00, 16'h7777);
    chk_alu("undefined_nop", 16'h5600);

    do_reset(1);
    chk_alu("midstream_reset_alu", 16'h0000);
    chk_flags("midstream_reset_flags", 5'b11111, 5'b00000);
    step(16'h2A00, 16'h0000);
    chk_alu("midstream_reset_rf", 16'h0000);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
